// File: rtl/irq_ports.sv
// Interrupt controller with per-source polarity, edge-detected sticky pending bits, enable mask and master enable.
// Optional macro IRQ_PORTS_SYNC_EN adds a two-flop synchronizer per source ahead of the edge detector.
module irq_ports #(
  parameter int                 N_SRC   = 4,
  parameter logic [N_SRC-1:0]   SRC_POL = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_stb,
  input  logic [1:0]       addr,
  input  logic [7:0]       wrdata,
  output logic [7:0]       rddata,
  input  logic [N_SRC-1:0] src_irq,
  output logic [N_SRC-1:0] src_ena,
  output logic             irq
);

  localparam logic [1:0] A_SWSET = 2'b00;
  localparam logic [1:0] A_RAW   = 2'b01;
  localparam logic [1:0] A_PEND  = 2'b10;
  localparam logic [1:0] A_ENA   = 2'b11;

  logic [N_SRC-1:0] qual;
  logic [N_SRC-1:0] s1_d;
  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] s2;
  logic [N_SRC-1:0] src_event;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] sw_set;
  logic [N_SRC-1:0] w1c;
  logic             men;
  logic             wr_ena;
  logic             unused_wrdata;

  assign qual = ~(src_irq ^ SRC_POL);

`ifdef IRQ_PORTS_SYNC_EN
  logic [N_SRC-1:0] sync0;
  logic [N_SRC-1:0] sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= qual;
      sync1 <= sync0;
    end
  end

  assign s1_d = sync1;
`else
  assign s1_d = qual;
`endif

  // Edge history resets to all-ones so a source already active at reset release raises no event
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= s1_d;
      s2 <= s1;
    end
  end

  assign src_event = s1 & ~s2;

  assign wr_ena = wr_stb && (addr == A_ENA);
  assign sw_set = (wr_stb && (addr == A_SWSET)) ? wrdata[N_SRC-1:0] : '0;
  assign w1c    = (wr_stb && (addr == A_PEND))  ? wrdata[N_SRC-1:0] : '0;

  // Any set source beats a W1C clear of the same bit
  assign pend_next = (pending & ~w1c) | src_event | sw_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      src_ena <= '0;
      men     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      pending <= pend_next;
      irq     <= men & (|(pending & src_ena));
      if (wr_ena) begin
        src_ena <= wrdata[N_SRC-1:0];
        men     <= wrdata[7];
      end
    end
  end

  always_comb begin
    rddata = '0;
    case (addr)
      A_ENA: begin
        rddata[N_SRC-1:0] = src_ena;
        rddata[7]         = men;
      end
      A_PEND: rddata[N_SRC-1:0] = pending;
      A_RAW: begin
        rddata[N_SRC-1:0] = s1;
        rddata[7]         = irq;
      end
      default: rddata = '0;
    endcase
  end

  assign unused_wrdata = ^wrdata;

endmodule

// File: tb/tb_irq_ports.sv
// Self-checking bench for irq_ports: register table vectors plus edge/latency/reset/polarity sequences.
// Latency expectations track the IRQ_PORTS_SYNC_EN build macro.
module tb_irq_ports;

`ifdef IRQ_PORTS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic       wr_stb;
  logic [1:0] addr;
  logic [7:0] wrdata;
  logic [7:0] rddata;
  logic [3:0] src_irq;
  logic [3:0] src_ena;
  logic       irq;
  logic [7:0] rddata_p;
  logic [3:0] src_irq_p;
  logic [3:0] src_ena_p;
  logic       irq_p;

  int checks = 0;
  int errors = 0;

  irq_ports #(.N_SRC(4)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .addr(addr), .wrdata(wrdata),
    .rddata(rddata), .src_irq(src_irq), .src_ena(src_ena), .irq(irq)
  );

  irq_ports #(.N_SRC(4), .SRC_POL(4'b1110)) dut_pol (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .addr(addr), .wrdata(wrdata),
    .rddata(rddata_p), .src_irq(src_irq_p), .src_ena(src_ena_p), .irq(irq_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_stb = wr;
    addr   = a;
    wrdata = d;
    @(posedge clk);
    #1;
    wr_stb = 1'b0;
  endtask

  task automatic readAt(input logic [1:0] a);
    addr = a;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    wr_stb    = 1'b0;
    addr      = 2'b00;
    wrdata    = 8'h00;
    src_irq   = 4'b0000;
    src_irq_p = 4'b0001;

    vecs[0]  = '{1'b1, 2'b11, 8'hFF, 2'b11, 8'h8F, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 8'h05, 2'b10, 8'h05, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 8'h00, 2'b01, 8'h80, 1'b1};
    vecs[3]  = '{1'b1, 2'b10, 8'h01, 2'b10, 8'h04, 1'b1};
    vecs[4]  = '{1'b1, 2'b10, 8'h00, 2'b10, 8'h04, 1'b1};
    vecs[5]  = '{1'b1, 2'b11, 8'h0B, 2'b11, 8'h0B, 1'b1};
    vecs[6]  = '{1'b0, 2'b11, 8'hFF, 2'b11, 8'h0B, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 8'h84, 2'b11, 8'h84, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 2'b00, 8'hF0, 2'b10, 8'h04, 1'b1};
    vecs[10] = '{1'b1, 2'b10, 8'hFF, 2'b10, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 8'h00, 2'b10, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 2'b01, 8'hFF, 2'b01, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 2'b00, 8'h08, 2'b10, 8'h08, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 8'h00, 2'b11, 8'h84, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    readAt(2'b11);
    checkOutput("rst_ena", rddata, 8'h00);
    readAt(2'b10);
    checkOutput("rst_pend", rddata, 8'h00);
    checkOutput("rst_irq", {7'd0, irq}, 8'h00);
    checkOutput("rst_irq_pol", {7'd0, irq_p}, 8'h00);
    repeat (6) @(posedge clk);

    // Register-path table
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].waddr, vecs[i].wdata);
      readAt(vecs[i].raddr);
      checkOutput($sformatf("vec%0d_rd", i), rddata, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].exp_irq});
    end

    // Source 0 rising edge: pending and irq latency, RAW readback
    applyStimulus(1'b1, 2'b10, 8'hFF);
    applyStimulus(1'b1, 2'b11, 8'h85);
    @(negedge clk);
    src_irq[0] = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
    readAt(2'b10);
    checkOutput("lat_pend_early", rddata, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("lat_pend", rddata, 8'h01);
    checkOutput("lat_irq_early", {7'd0, irq}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("lat_irq", {7'd0, irq}, 8'h01);
    readAt(2'b01);
    checkOutput("lat_raw", rddata, 8'h81);

    // Held level: one event only, W1C clears and stays clear
    repeat (20) @(posedge clk);
    #1;
    readAt(2'b10);
    checkOutput("hold_pend", rddata, 8'h01);
    applyStimulus(1'b1, 2'b10, 8'h01);
    #1;
    checkOutput("hold_clr", rddata, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("hold_irq_off", {7'd0, irq}, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold_no_reset", rddata, 8'h00);
    @(negedge clk);
    src_irq[0] = 1'b0;
    repeat (LAT + 3) @(posedge clk);

    // Event on source 2 coincident with W1C of bit 2: set wins
    applyStimulus(1'b1, 2'b00, 8'h04);
    @(negedge clk);
    src_irq[2] = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    applyStimulus(1'b1, 2'b10, 8'h04);
    readAt(2'b10);
    checkOutput("race_pend", rddata, 8'h04);
    @(posedge clk);
    #1;
    checkOutput("race_irq", {7'd0, irq}, 8'h01);
    applyStimulus(1'b1, 2'b10, 8'hFF);
    readAt(2'b10);
    checkOutput("race_clr", rddata, 8'h00);
    @(negedge clk);
    src_irq[2] = 1'b0;

    // Source 1 active through reset; reset also beats a concurrent ENA write
    src_irq[1] = 1'b1;
    rst        = 1'b1;
    wr_stb     = 1'b1;
    addr       = 2'b11;
    wrdata     = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    wr_stb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    readAt(2'b11);
    checkOutput("rstdom_ena", rddata, 8'h00);
    applyStimulus(1'b1, 2'b11, 8'hFF);
    repeat (6) @(posedge clk);
    #1;
    readAt(2'b10);
    checkOutput("rsthold_pend", rddata, 8'h00);
    checkOutput("rsthold_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    src_irq[1] = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    src_irq[1] = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    readAt(2'b10);
    checkOutput("rearm_pend", rddata, 8'h02);
    @(posedge clk);
    #1;
    checkOutput("rearm_irq", {7'd0, irq}, 8'h01);

    // Active-low source 0 on the polarity instance; MEN gating
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    src_irq_p[0] = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    readAt(2'b10);
    checkOutput("pol_pend", rddata_p, 8'h01);
    applyStimulus(1'b1, 2'b11, 8'h01);
    checkOutput("pol_men0_a", {7'd0, irq_p}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("pol_men0_b", {7'd0, irq_p}, 8'h00);
    applyStimulus(1'b1, 2'b11, 8'h81);
    checkOutput("pol_men1_early", {7'd0, irq_p}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("pol_men1", {7'd0, irq_p}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ports.md
IRQ_PORTS -- requirements
Module: irq_ports

Interface
REQ-001 Parameter N_SRC, default 4, number of interrupt sources, legal 1..7.
REQ-002 Parameter SRC_POL, default {N_SRC{1'b1}}, per-source polarity; 1 = active-high, 0 = active-low.
REQ-003 clk  input  1  single clock; all flops on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_stb  input  1  write request; one write per cycle sampled high.
REQ-006 addr  input  2  register select.
REQ-007 wrdata  input  8  write data.
REQ-008 rddata  output  8  read data for addr, combinational from register state.
REQ-009 src_irq  input  N_SRC  raw interrupt sources.
REQ-010 src_ena  output  N_SRC  per-source enable register contents.
REQ-011 irq  output  1  registered, active-high combined interrupt request.

Function
REQ-012 addr 2'b11 ENA, R/W: bits[N_SRC-1:0] = src_ena; bit7 = master enable MEN; other bits read 0, ignore writes.
REQ-013 addr 2'b10 PEND, R/W1C: bits[N_SRC-1:0] = sticky pending; writing 1 clears a bit, writing 0 leaves it; other bits read 0.
REQ-014 addr 2'b01 RAW, read-only: bits[N_SRC-1:0] = qualified sampled sources; bit7 = irq; writes ignored.
REQ-015 addr 2'b00 SWSET, write-only: writing 1 to bit i (i<N_SRC) sets pending[i]; reads 8'h00.
REQ-016 Qualified source q[i] = src_irq[i] XNOR SRC_POL[i], sampled into s1 each cycle; history s2 <= s1.
REQ-017 Event[i] = s1[i] & ~s2[i] (rising edge of qualified source); levels held high produce exactly one event.
REQ-018 pending[i] sets on the cycle after event[i] or SWSET write bit i.
REQ-019 Simultaneous set (event or SWSET) and W1C clear of the same bit: set wins, bit stays 1.
REQ-020 irq <= MEN & |(pending & src_ena), registered; one cycle after pending/ena/MEN change.
REQ-021 Latency: source asserted before edge k -> s1 at k, pending at k+1, irq at k+2.
REQ-022 Pending bits set regardless of src_ena; enabling a pending source raises irq one cycle later.
REQ-023 Write to ENA and concurrent event: both take effect in the same cycle, independently.

Reset
REQ-024 On rst: src_ena=0, MEN=0, pending=0, irq=0; s1 and s2 (and sync stages) load 1s.
REQ-025 Consequence: a source qualified-active through reset release generates no event until it deasserts and reasserts.
REQ-026 rst dominates wr_stb and events in the same cycle.

Configuration
REQ-027 Macro IRQ_PORTS_SYNC_EN defined: two-flop synchronizer per source ahead of s1, reset to 1; latency becomes pending at k+3, irq at k+4.
REQ-028 IRQ_PORTS_SYNC_EN undefined: src_irq treated as synchronous to clk, latency per REQ-021; all other behaviour identical.

Verification
REQ-029 N_SRC=4, rst released; write ENA=8'h85; src_irq[0] 0->1 before edge k -> pending=4'b0001 at k+1, irq=1 at k+2, RAW=8'h81 thereafter.
REQ-030 src_irq[0] held high for 20 cycles, then write PEND=8'h01 -> pending[0]=0, irq=0 next cycle, no re-set while still high.
REQ-031 Same cycle: event on src 2 and PEND write 8'h04 -> pending[2] remains 1.
REQ-032 src_irq[1] held high across rst release, ENA=8'hFF -> pending stays 0; drop then raise -> pending[1]=1.
REQ-033 SRC_POL=4'b1110, src_irq[0] 1->0 -> pending[0]=1; ENA=8'h01 (MEN=0) -> irq stays 0; ENA=8'h81 -> irq=1 next cycle.
REQ-034 Build with IRQ_PORTS_SYNC_EN: repeat REQ-029 -> pending at k+3, irq at k+4; SWSET write 8'h08 -> pending[3]=1 next cycle.
